// File: rtl/dec_entry_to_snum.sv
`default_nettype none
// ============================================================================
// Module      : dec_entry_to_snum
// Description : Decimal keypad entry accumulator. It rebuilds a magnitude
//               from keyed BCD digits as mag*10 + d and holds a sign that the
//               neg key toggles. On enter it commits a 9-bit two's-complement
//               value. The live magnitude and sign feed the display chain.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_entry_to_snum (
    input  logic       clk,
    input  logic       reset,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       neg_key,
    input  logic       clear,
    input  logic       enter,
    output logic [7:0] mag,
    output logic       neg,
    output logic [1:0] ndigits,
    output logic [8:0] value_out,
    output logic       out_valid,
    output logic       err
);

    // EMPTY: no digits, ENTRY: 1-2 digits, FULL: 3 digits
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0]  c_MAX_DIGITS = 2'd3;
    localparam logic [11:0] c_MAX_MAG    = 12'd255;
    localparam logic [3:0]  c_MAX_BCD    = 4'd9;

    state_t      r_state;
    logic [7:0]  r_mag;
    logic        r_neg;
    logic [1:0]  r_ndigits;
    logic [8:0]  r_value;
    logic        r_out_valid;
    logic        r_err;

    state_t      w_state_nxt;
    logic [7:0]  w_mag_nxt;
    logic        w_neg_nxt;
    logic [1:0]  w_ndigits_nxt;
    logic [8:0]  w_value_nxt;
    logic        w_out_valid_nxt;
    logic        w_err_nxt;

    logic [11:0] w_mag_ext;
    logic [11:0] w_sum;
    logic [8:0]  w_mag9;
    logic [8:0]  w_signed;
    logic [1:0]  w_ndigits_inc;

    // Shift-add times ten, wide enough that 255*10+9 cannot wrap
    always_comb begin
        w_mag_ext     = {4'b0000, r_mag};
        w_sum         = (w_mag_ext << 3) + (w_mag_ext << 1) + {8'b0000_0000, digit};
        w_mag9        = {1'b0, r_mag};
        // Negating zero yields zero, so a live -0 commits as plain 0
        w_signed      = r_neg ? (~w_mag9 + 9'd1) : w_mag9;
        w_ndigits_inc = r_ndigits + 2'd1;
    end

    // Next-state: only the highest-priority strobe acts (clear > enter > digit > neg)
    always_comb begin
        w_state_nxt     = r_state;
        w_mag_nxt       = r_mag;
        w_neg_nxt       = r_neg;
        w_ndigits_nxt   = r_ndigits;
        w_value_nxt     = r_value;
        w_out_valid_nxt = 1'b0;
        w_err_nxt       = r_err;

        if (clear) begin
            w_state_nxt   = EMPTY;
            w_mag_nxt     = 8'd0;
            w_neg_nxt     = 1'b0;
            w_ndigits_nxt = 2'd0;
            w_err_nxt     = 1'b0;
        end else if (enter) begin
            // Enter with nothing keyed is ignored, but still masks lower strobes
            if (r_state != EMPTY) begin
                w_value_nxt     = w_signed;
                w_out_valid_nxt = 1'b1;
                w_err_nxt       = 1'b0;
                w_state_nxt     = EMPTY;
                w_mag_nxt       = 8'd0;
                w_neg_nxt       = 1'b0;
                w_ndigits_nxt   = 2'd0;
            end
        end else if (digit_valid) begin
            if (digit > c_MAX_BCD) begin
                w_err_nxt = 1'b1;
            end else if (r_state == FULL) begin
                // A fourth digit is refused even when the sum would fit
                w_err_nxt = 1'b1;
            end else if (w_sum > c_MAX_MAG) begin
                w_err_nxt = 1'b1;
            end else begin
                w_mag_nxt     = w_sum[7:0];
                w_ndigits_nxt = w_ndigits_inc;
                w_state_nxt   = (w_ndigits_inc == c_MAX_DIGITS) ? FULL : ENTRY;
            end
        end else if (neg_key) begin
            w_neg_nxt = ~r_neg;
        end
    end

    // State and output registers; reset clears everything, including a pending pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_mag       <= 8'd0;
            r_neg       <= 1'b0;
            r_ndigits   <= 2'd0;
            r_value     <= 9'd0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mag       <= w_mag_nxt;
            r_neg       <= w_neg_nxt;
            r_ndigits   <= w_ndigits_nxt;
            r_value     <= w_value_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign mag       = r_mag;
    assign neg       = r_neg;
    assign ndigits   = r_ndigits;
    assign value_out = r_value;
    assign out_valid = r_out_valid;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dec_entry_to_snum.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_entry_to_snum
// Description : Directed self-checking bench for dec_entry_to_snum
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_entry_to_snum;

    logic       clk;
    logic       reset;
    logic       digit_valid;
    logic [3:0] digit;
    logic       neg_key;
    logic       clear;
    logic       enter;
    logic [7:0] mag;
    logic       neg;
    logic [1:0] ndigits;
    logic [8:0] value_out;
    logic       out_valid;
    logic       err;

    int checks;
    int failures;

    dec_entry_to_snum dut (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .neg_key     (neg_key),
        .clear       (clear),
        .enter       (enter),
        .mag         (mag),
        .neg         (neg),
        .ndigits     (ndigits),
        .value_out   (value_out),
        .out_valid   (out_valid),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of strobes: driven at negedge, released 1 ns after the rising edge
    task automatic step(input logic cl, input logic en, input logic dv,
                        input logic [3:0] d, input logic nk);
        @(negedge clk);
        clear = cl; enter = en; digit_valid = dv; digit = d; neg_key = nk;
        @(posedge clk);
        #1;
        clear = 1'b0; enter = 1'b0; digit_valid = 1'b0; digit = 4'd0; neg_key = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        step(1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mag, neg, ndigits, value_out, out_valid, err} !== 23'd0) begin
            failures++;
            $display("FAIL reset_state: got mag=%0d neg=%b nd=%0d val=%h ov=%b err=%b, want all 0",
                     mag, neg, ndigits, value_out, out_valid, err);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_commit;
        key(4'd1);
        checks++;
        if ({mag, ndigits} !== {8'd1, 2'd1}) begin
            failures++; $display("FAIL digit_1: got mag=%0d nd=%0d want 1/1", mag, ndigits);
        end
        key(4'd2);
        checks++;
        if ({mag, ndigits} !== {8'd12, 2'd2}) begin
            failures++; $display("FAIL digit_12: got mag=%0d nd=%0d want 12/2", mag, ndigits);
        end
        key(4'd7);
        checks++;
        if ({mag, ndigits, err} !== {8'd127, 2'd3, 1'b0}) begin
            failures++; $display("FAIL digit_127: got mag=%0d nd=%0d err=%b want 127/3/0", mag, ndigits, err);
        end
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        checks++;
        if ({neg, mag} !== {1'b1, 8'd127}) begin
            failures++; $display("FAIL neg_toggle: got neg=%b mag=%0d want 1/127", neg, mag);
        end
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        checks++;
        if ({value_out, out_valid, mag, neg, ndigits} !== {9'h181, 1'b1, 8'd0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL commit_m127: got val=%h ov=%b mag=%0d neg=%b nd=%0d want 181/1/0/0/0",
                     value_out, out_valid, mag, neg, ndigits);
        end
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++;
        if ({out_valid, value_out} !== {1'b0, 9'h181}) begin
            failures++; $display("FAIL pulse_width: got ov=%b val=%h want 0/181", out_valid, value_out);
        end
    endtask

    task automatic test_overflow;
        key(4'd2); key(4'd5); key(4'd6);
        checks++;
        if ({mag, ndigits, err} !== {8'd25, 2'd2, 1'b1}) begin
            failures++; $display("FAIL overflow_reject: got mag=%0d nd=%0d err=%b want 25/2/1", mag, ndigits, err);
        end
        key(4'd5);
        checks++;
        if ({mag, ndigits, err} !== {8'd255, 2'd3, 1'b1}) begin
            failures++; $display("FAIL max_255: got mag=%0d nd=%0d err=%b want 255/3/1", mag, ndigits, err);
        end
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        checks++;
        if ({value_out, out_valid, err} !== {9'h0FF, 1'b1, 1'b0}) begin
            failures++; $display("FAIL commit_255: got val=%h ov=%b err=%b want 0ff/1/0", value_out, out_valid, err);
        end
    endtask

    task automatic test_full_and_illegal;
        key(4'd0); key(4'd0); key(4'd7);
        checks++;
        if ({mag, ndigits, err} !== {8'd7, 2'd3, 1'b0}) begin
            failures++; $display("FAIL leading_zeros: got mag=%0d nd=%0d err=%b want 7/3/0", mag, ndigits, err);
        end
        key(4'd3);
        checks++;
        if ({mag, ndigits, err} !== {8'd7, 2'd3, 1'b1}) begin
            failures++; $display("FAIL fourth_digit: got mag=%0d nd=%0d err=%b want 7/3/1", mag, ndigits, err);
        end
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++;
        if ({mag, ndigits, neg, err, value_out} !== {8'd0, 2'd0, 1'b0, 1'b0, 9'h0FF}) begin
            failures++;
            $display("FAIL clear: got mag=%0d nd=%0d neg=%b err=%b val=%h want 0/0/0/0/0ff",
                     mag, ndigits, neg, err, value_out);
        end
        key(4'd12);
        checks++;
        if ({mag, ndigits, err} !== {8'd0, 2'd0, 1'b1}) begin
            failures++; $display("FAIL illegal_code: got mag=%0d nd=%0d err=%b want 0/0/1", mag, ndigits, err);
        end
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_empty_enter;
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        checks++;
        if ({out_valid, value_out} !== {1'b0, 9'h0FF}) begin
            failures++; $display("FAIL empty_enter: got ov=%b val=%h want 0/0ff", out_valid, value_out);
        end
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        key(4'd0);
        checks++;
        if ({neg, mag, ndigits} !== {1'b1, 8'd0, 2'd1}) begin
            failures++; $display("FAIL neg_zero_live: got neg=%b mag=%0d nd=%0d want 1/0/1", neg, mag, ndigits);
        end
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        checks++;
        if ({value_out, out_valid} !== {9'h000, 1'b1}) begin
            failures++; $display("FAIL neg_zero_commit: got val=%h ov=%b want 000/1", value_out, out_valid);
        end
    endtask

    task automatic test_priority;
        key(4'd1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        key(4'd4); key(4'd5);
        checks++;
        if (mag !== 8'd45) begin
            failures++; $display("FAIL setup_45: got mag=%0d want 45", mag);
        end
        step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
        checks++;
        if ({mag, ndigits, out_valid, value_out} !== {8'd0, 2'd0, 1'b0, 9'h001}) begin
            failures++;
            $display("FAIL clear_wins: got mag=%0d nd=%0d ov=%b val=%h want 0/0/0/001",
                     mag, ndigits, out_valid, value_out);
        end
        key(4'd4); key(4'd2);
        step(1'b0, 1'b1, 1'b1, 4'd8, 1'b0);
        checks++;
        if ({value_out, out_valid, mag, ndigits} !== {9'h02A, 1'b1, 8'd0, 2'd0}) begin
            failures++;
            $display("FAIL enter_wins: got val=%h ov=%b mag=%0d nd=%0d want 02a/1/0/0",
                     value_out, out_valid, mag, ndigits);
        end
        step(1'b0, 1'b0, 1'b1, 4'd6, 1'b1);
        checks++;
        if ({mag, neg, ndigits} !== {8'd6, 1'b0, 2'd1}) begin
            failures++; $display("FAIL digit_over_neg: got mag=%0d neg=%b nd=%0d want 6/0/1", mag, neg, ndigits);
        end
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_reset_mid_entry;
        key(4'd9); key(4'd9);
        @(negedge clk);
        enter = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if ({mag, neg, ndigits, value_out, out_valid, err} !== 23'd0) begin
            failures++;
            $display("FAIL async_reset: got mag=%0d nd=%0d val=%h ov=%b want all 0", mag, ndigits, value_out, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, value_out} !== {1'b0, 9'h000}) begin
            failures++; $display("FAIL reset_kills_pulse: got ov=%b val=%h want 0/000", out_valid, value_out);
        end
        @(negedge clk);
        reset = 1'b0;
        enter = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, mag, value_out} !== {1'b0, 8'd0, 9'h000}) begin
            failures++; $display("FAIL after_reset: got ov=%b mag=%0d val=%h want 0/0/000", out_valid, mag, value_out);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        digit_valid = 1'b0; digit = 4'd0; neg_key = 1'b0; clear = 1'b0; enter = 1'b0;
        test_reset;
        test_basic_commit;
        test_overflow;
        test_full_and_illegal;
        test_empty_enter;
        test_priority;
        test_reset_mid_entry;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
